fifo_merge_arbiter: RTL and testbench
=====================================

Name: fifo_merge_arbiter

Overview:
- Registered merge stage between the per-channel word FIFOs (fei4_rx channels, tlu_controller) and the SRAM FIFO input port.
- Replaces the combinational arbiter and mux with a burst-locking round-robin arbiter plus a 2-entry output skid buffer.
- Breaks the timing path from source FIFO flags to the SRAM FIFO's read strobe.
- Honours the TLU preempt request, so trigger words are never starved behind FE data.

Parameters:
- N_SRC, 5, number of 32-bit word sources (2..8).
- BURST_MAX, 16, maximum words taken from one source per grant (1..255).
- PRIO_SRC, 0, index of the source served first when PREEMPT_REQ is high.

Ports:
- BUS_CLK  input  1  single clock for the whole block.
- BUS_RST  input  1  reset, asynchronous, active-high.
- SRC_EMPTY  input  N_SRC  per-source FIFO empty flag; first-word-fall-through sources.
- SRC_DATA  input  32*N_SRC  per-source head word; slice i is bits [32*i+31:32*i].
- SRC_READ  output  N_SRC  per-source pop strobe, one-hot or zero.
- PREEMPT_REQ  input  1  priority request for source PRIO_SRC.
- OUT_READ  input  1  sink pop (FIFO_READ_NEXT_OUT of sram_fifo).
- OUT_EMPTY  output  1  no word available to the sink.
- OUT_DATA  output  32  head word of the output buffer.
- OUT_READ_ERR  output  1  1-cycle pulse: OUT_READ while OUT_EMPTY.
- GRANT  output  N_SRC  one-hot current owner; zero when idle.

Behaviour:
- Reset values: OUT_EMPTY=1, OUT_DATA=0, SRC_READ=0, GRANT=0, OUT_READ_ERR=0; buffer count=0, round-robin pointer=0, burst_cnt=0, FSM=IDLE.
- Reset mid-transfer drops buffered words and the grant immediately. No SRC_READ is issued while BUS_RST is high.
- Output buffer:
  - 2-entry FIFO, count 0..2; OUT_DATA is the head entry, OUT_EMPTY = (count==0).
  - Pop on OUT_READ & ~OUT_EMPTY.
  - space = (count<2) | (OUT_READ & ~OUT_EMPTY).
  - Simultaneous push and pop keeps the count unchanged and preserves order.
- SRC_READ[i] = GRANT[i] & ~SRC_EMPTY[i] & space & (FSM==LOCKED). It is combinational from registered state and OUT_READ.
- The word on SRC_DATA slice i is written into the buffer on the same edge as the pop.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If PREEMPT_REQ and ~SRC_EMPTY[PRIO_SRC], grant PRIO_SRC.
  - Otherwise grant the first non-empty source scanning from rr_ptr upward, wrapping at N_SRC.
  - Registered: GRANT is set at the next edge, the FSM moves to LOCKED and burst_cnt is cleared.
  - No non-empty source: stay in IDLE, GRANT=0.
- LOCKED:
  - Each SRC_READ increments burst_cnt (8-bit).
  - Release to IDLE on the edge where any of these holds:
    - SRC_EMPTY of the owner is high, and no pop occurs that cycle;
    - a pop makes burst_cnt reach BURST_MAX;
    - PREEMPT_REQ=1 while the owner != PRIO_SRC (release after the word popped that cycle, if any).
  - On release: GRANT=0, rr_ptr = owner+1 mod N_SRC.
  - When PREEMPT_REQ forced the grant, rr_ptr is not advanced.
- Latency: a word appearing at an idle source with an empty buffer gives GRANT at edge 1, SRC_READ during cycle 2, and OUT_EMPTY=0 after edge 2.
- Throughput: 1 word/cycle while locked and the sink pops every cycle. There is 1 idle cycle per re-arbitration.
- The owner going empty mid-burst with data returning one cycle later: already released, so the source is re-arbitrated normally.
- OUT_READ while OUT_EMPTY: the buffer is unchanged and OUT_READ_ERR pulses for 1 cycle.
- No word is duplicated or lost under any OUT_READ / SRC_EMPTY pattern.

Optional Feature:
- Macro FIFO_MERGE_STATS_EN.
- With the macro defined:
  - Adds output WORD_CNT [31:0]: total words pushed into the buffer, saturating at 0xFFFFFFFF, reset 0.
  - Adds output PREEMPT_CNT [15:0]: preempt-forced releases, saturating, reset 0.
- Without the macro: neither port nor its counter exists, and all other behaviour is identical.

Test Plan:
- N_SRC=5 defaults; source 2 holds 3 words (A,B,C), OUT_READ held high -> GRANT=00100 after 1 edge; A,B,C on OUT_DATA in order on consecutive cycles; then GRANT=0 and OUT_EMPTY=1.
- Sources 1 and 3 each hold 40 words, BURST_MAX=16, sink always popping -> bursts of 16,16,16,16,8,8 alternating 1,3,1,3,1,3; total 80 words, no loss.
- Source 4 bursting; raise PREEMPT_REQ with source 0 holding 2 words -> source 4 released within 1 cycle; next GRANT=00001; both words out; rr_ptr unchanged, so source 4 is regranted next.
- Sink stalls: OUT_READ=0 with source 1 holding 5 words -> exactly 2 pops; count=2; SRC_READ=0 until OUT_READ resumes; then the remaining 3 words follow in order.
- OUT_READ pulse while OUT_EMPTY=1 -> OUT_READ_ERR high exactly 1 cycle; buffer unchanged. Assert BUS_RST with count=2 mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_merge_arbiter.sv
// Registered merge of N_SRC first-word-fall-through FIFOs into a 2-entry skid buffer.
// A burst-locking round-robin arbiter picks the source, and PREEMPT_REQ favours PRIO_SRC.
// Defining FIFO_MERGE_STATS_EN adds the WORD_CNT and PREEMPT_CNT statistics outputs.
module fifo_merge_arbiter #(
    parameter int N_SRC     = 5,
    parameter int BURST_MAX = 16,
    parameter int PRIO_SRC  = 0
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [N_SRC-1:0]     SRC_EMPTY,
    input  logic [32*N_SRC-1:0]  SRC_DATA,
    output logic [N_SRC-1:0]     SRC_READ,
    input  logic                 PREEMPT_REQ,
    input  logic                 OUT_READ,
    output logic                 OUT_EMPTY,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_READ_ERR,
    output logic [N_SRC-1:0]     GRANT
`ifdef FIFO_MERGE_STATS_EN
    ,
    output logic [31:0]          WORD_CNT,
    output logic [15:0]          PREEMPT_CNT
`endif
);
    localparam int IW = $clog2(N_SRC);
    localparam logic [N_SRC-1:0] ONE = 1;

    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;

    logic [IW-1:0] owner, rr_ptr, rr_pick, sel;
    logic [7:0]    burst_cnt;
    logic          forced;
    logic [31:0]   buf0, buf1;
    logic [1:0]    count;
    logic          pop, push, space, found, take_prio;
    logic          empty_rel, burst_rel, preempt_rel, release_now;
    logic [31:0]   push_data;

    assign OUT_EMPTY = (count == 2'd0);
    assign OUT_DATA  = buf0;
    assign pop       = OUT_READ & ~OUT_EMPTY;
    assign space     = (count != 2'd2) | pop;
    assign SRC_READ  = (state == LOCKED && space) ? (GRANT & ~SRC_EMPTY) : '0;
    assign push      = |SRC_READ;
    assign push_data = SRC_DATA[32*owner +: 32];

    // Round-robin scan from rr_ptr; iterating downward lets the nearest hit win.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        rr_pick = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!SRC_EMPTY[idx]) begin
                found   = 1'b1;
                rr_pick = IW'(idx);
            end
        end
    end

    assign take_prio   = PREEMPT_REQ & ~SRC_EMPTY[PRIO_SRC];
    assign sel         = take_prio ? IW'(PRIO_SRC) : rr_pick;
    assign empty_rel   = SRC_EMPTY[owner] & ~push;
    assign burst_rel   = push && (burst_cnt == 8'(BURST_MAX - 1));
    assign preempt_rel = PREEMPT_REQ && (owner != IW'(PRIO_SRC));
    assign release_now = empty_rel | burst_rel | preempt_rel;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= IDLE;
            GRANT     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            forced    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_prio || found) begin
                        state     <= LOCKED;
                        owner     <= sel;
                        GRANT     <= ONE << sel;
                        forced    <= take_prio;
                        burst_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (push) burst_cnt <= burst_cnt + 8'd1;
                    if (release_now) begin
                        state <= IDLE;
                        GRANT <= '0;
                        // A preempt-forced grant must not disturb the round-robin order.
                        if (!forced)
                            rr_ptr <= (owner == IW'(N_SRC - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            count        <= 2'd0;
            buf0         <= '0;
            buf1         <= '0;
            OUT_READ_ERR <= 1'b0;
        end else begin
            OUT_READ_ERR <= OUT_READ & OUT_EMPTY;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= push_data;
                    else               buf1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= push_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_MERGE_STATS_EN
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            WORD_CNT    <= '0;
            PREEMPT_CNT <= '0;
        end else begin
            if (push && WORD_CNT != 32'hFFFF_FFFF) WORD_CNT <= WORD_CNT + 32'd1;
            if (state == LOCKED && preempt_rel && PREEMPT_CNT != 16'hFFFF)
                PREEMPT_CNT <= PREEMPT_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_merge_arbiter.sv
// Directed bench for fifo_merge_arbiter: FWFT source models, a pop/read monitor,
// and one task per scenario with hand-computed expectations.
module tb_fifo_merge_arbiter;
    localparam int N = 5;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST;
    logic [N-1:0]      SRC_EMPTY;
    logic [32*N-1:0]   SRC_DATA;
    logic [N-1:0]      SRC_READ;
    logic              PREEMPT_REQ;
    logic              OUT_READ;
    logic              OUT_EMPTY;
    logic [31:0]       OUT_DATA;
    logic              OUT_READ_ERR;
    logic [N-1:0]      GRANT;
`ifdef FIFO_MERGE_STATS_EN
    logic [31:0]       WORD_CNT;
    logic [15:0]       PREEMPT_CNT;
`endif

    fifo_merge_arbiter #(.N_SRC(N), .BURST_MAX(16), .PRIO_SRC(0)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA), .SRC_READ(SRC_READ),
        .PREEMPT_REQ(PREEMPT_REQ), .OUT_READ(OUT_READ),
        .OUT_EMPTY(OUT_EMPTY), .OUT_DATA(OUT_DATA), .OUT_READ_ERR(OUT_READ_ERR),
        .GRANT(GRANT)
`ifdef FIFO_MERGE_STATS_EN
        , .WORD_CNT(WORD_CNT), .PREEMPT_CNT(PREEMPT_CNT)
`endif
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Source FIFOs: rd advances on the DUT's pops, wr only from the tasks.
    logic [31:0] smem [N][64];
    int rd [N];
    int wr [N];

    always_comb begin
        SRC_EMPTY = '1;
        SRC_DATA  = '0;
        for (int i = 0; i < N; i++) begin
            SRC_EMPTY[i]         = (rd[i] == wr[i]);
            SRC_DATA[32*i +: 32] = smem[i][rd[i] % 64];
        end
    end

    always @(posedge BUS_CLK)
        for (int i = 0; i < N; i++)
            if (SRC_READ[i]) rd[i] <= rd[i] + 1;

    logic [31:0] out_log [$];
    int          out_cyc [$];
    int          src_log [$];
    int          err_cnt = 0;
    int          cyc = 0;
    int          vecs = 0;
    int          errs = 0;

    always @(posedge BUS_CLK) cyc <= cyc + 1;

    always @(negedge BUS_CLK) begin
        #1;
        if (OUT_READ && !OUT_EMPTY) begin
            out_log.push_back(OUT_DATA);
            out_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++)
            if (SRC_READ[i]) src_log.push_back(i);
        if (OUT_READ_ERR) err_cnt = err_cnt + 1;
    end

    task automatic push_word(input int s, input logic [31:0] w);
        smem[s][wr[s] % 64] = w;
        wr[s] = wr[s] + 1;
    endtask

    task automatic do_reset();
        @(negedge BUS_CLK);
        BUS_RST = 1'b1;
        OUT_READ = 1'b0;
        PREEMPT_REQ = 1'b0;
        for (int i = 0; i < N; i++) wr[i] = rd[i];
        repeat (2) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vecs++; if (OUT_EMPTY !== 1'b1) begin errs++; $display("FAIL rst_out_empty: got %b want 1", OUT_EMPTY); end
        vecs++; if (OUT_DATA !== 32'h0) begin errs++; $display("FAIL rst_out_data: got %h want 0", OUT_DATA); end
        vecs++; if (SRC_READ !== 5'b0) begin errs++; $display("FAIL rst_src_read: got %b want 00000", SRC_READ); end
        vecs++; if (GRANT !== 5'b0) begin errs++; $display("FAIL rst_grant: got %b want 00000", GRANT); end
        vecs++; if (OUT_READ_ERR !== 1'b0) begin errs++; $display("FAIL rst_read_err: got %b want 0", OUT_READ_ERR); end
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        logic [31:0] got;
        int ob, n;
        bit ok;
        exp = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
        do_reset();
        ob = out_log.size();
        @(negedge BUS_CLK);
        for (int k = 0; k < 3; k++) push_word(2, exp[k]);
        OUT_READ = 1'b1;
        @(posedge BUS_CLK); #1;
        vecs++; if (GRANT !== 5'b00100) begin errs++; $display("FAIL basic_grant: got %b want 00100", GRANT); end
        vecs++; if (SRC_READ !== 5'b00100) begin errs++; $display("FAIL basic_src_read: got %b want 00100", SRC_READ); end
        @(posedge BUS_CLK); #1;
        vecs++; if (OUT_EMPTY !== 1'b0 || OUT_DATA !== exp[0]) begin
            errs++; $display("FAIL basic_latency: got empty=%b data=%h want 0 %h", OUT_EMPTY, OUT_DATA, exp[0]);
        end
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge BUS_CLK); #1;
            if (GRANT === 5'b0 && OUT_EMPTY === 1'b1) begin ok = 1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL basic_done: got grant=%b empty=%b want 0 1", GRANT, OUT_EMPTY); end
        @(negedge BUS_CLK); OUT_READ = 1'b0;
        n = out_log.size() - ob;
        vecs++; if (n != 3) begin errs++; $display("FAIL basic_count: got %0d want 3", n); end
        for (int k = 0; k < 3; k++) begin
            got = (ob + k < out_log.size()) ? out_log[ob + k] : 32'hxxxx_xxxx;
            vecs++; if (got !== exp[k]) begin errs++; $display("FAIL basic_word%0d: got %h want %h", k, got, exp[k]); end
        end
        vecs++;
        if (n != 3) begin
            errs++; $display("FAIL basic_consecutive: got %0d words want 3", n);
        end else if (out_cyc[ob+1] != out_cyc[ob] + 1 || out_cyc[ob+2] != out_cyc[ob] + 2) begin
            errs++; $display("FAIL basic_consecutive: got cycles %0d %0d %0d want consecutive",
                             out_cyc[ob], out_cyc[ob+1], out_cyc[ob+2]);
        end
    endtask

    task automatic test_bursts();
        int exp_src [6];
        int exp_len [6];
        int run_src [$];
        int run_len [$];
        int ob, sb, n, p1, p3, idx, bad, gs, gl;
        logic [31:0] e;
        bit ok;
        exp_src = '{1, 3, 1, 3, 1, 3};
        exp_len = '{16, 16, 16, 16, 8, 8};
        do_reset();
        ob = out_log.size();
        sb = src_log.size();
        @(negedge BUS_CLK);
        for (int k = 0; k < 40; k++) begin
            push_word(1, 32'h0100_0000 + k);
            push_word(3, 32'h0300_0000 + k);
        end
        OUT_READ = 1'b1;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge BUS_CLK); #1;
            if (SRC_EMPTY[1] && SRC_EMPTY[3] && GRANT === 5'b0 && OUT_EMPTY === 1'b1) begin ok = 1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL burst_done: got grant=%b want drained", GRANT); end
        @(negedge BUS_CLK); OUT_READ = 1'b0;
        for (int k = sb; k < src_log.size(); k++) begin
            if (run_src.size() == 0 || run_src[run_src.size()-1] != src_log[k]) begin
                run_src.push_back(src_log[k]);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            end
        end
        vecs++; if (run_src.size() != 6) begin errs++; $display("FAIL burst_runs: got %0d want 6", run_src.size()); end
        for (int r = 0; r < 6; r++) begin
            gs = (r < run_src.size()) ? run_src[r] : -1;
            gl = (r < run_len.size()) ? run_len[r] : -1;
            vecs++; if (gs != exp_src[r] || gl != exp_len[r]) begin
                errs++; $display("FAIL burst_run%0d: got src%0d x%0d want src%0d x%0d", r, gs, gl, exp_src[r], exp_len[r]);
            end
        end
        n = out_log.size() - ob;
        vecs++; if (n != 80) begin errs++; $display("FAIL burst_total: got %0d want 80", n); end
        p1 = 0; p3 = 0; idx = ob; bad = 0;
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < exp_len[r]; k++) begin
                if (exp_src[r] == 1) begin e = 32'h0100_0000 + p1; p1++; end
                else                 begin e = 32'h0300_0000 + p3; p3++; end
                if (idx >= out_log.size() || out_log[idx] !== e) bad++;
                idx++;
            end
        vecs++; if (bad != 0) begin errs++; $display("FAIL burst_order: got %0d wrong words want 0", bad); end
`ifdef FIFO_MERGE_STATS_EN
        vecs++; if (WORD_CNT !== 32'd80) begin errs++; $display("FAIL burst_word_cnt: got %0d want 80", WORD_CNT); end
`endif
    endtask

    task automatic test_preempt();
        int exp_src [12];
        logic [31:0] exp_w [12];
        int ob, sb, bad;
        bit ok;
        exp_src = '{4, 4, 4, 4, 0, 0, 4, 4, 4, 4, 4, 4};
        for (int k = 0; k < 4; k++) exp_w[k] = 32'h0400_0000 + k;
        exp_w[4] = 32'hEE00_0000;
        exp_w[5] = 32'hEE00_0001;
        for (int k = 4; k < 10; k++) exp_w[k + 2] = 32'h0400_0000 + k;
        do_reset();
        ob = out_log.size();
        sb = src_log.size();
        @(negedge BUS_CLK);
        for (int k = 0; k < 10; k++) push_word(4, 32'h0400_0000 + k);
        OUT_READ = 1'b1;
        repeat (4) @(negedge BUS_CLK);
        push_word(0, 32'hEE00_0000);
        push_word(0, 32'hEE00_0001);
        PREEMPT_REQ = 1'b1;
        @(posedge BUS_CLK); #1;
        vecs++; if (GRANT !== 5'b0) begin errs++; $display("FAIL preempt_release: got %b want 00000", GRANT); end
        @(posedge BUS_CLK); #1;
        vecs++; if (GRANT !== 5'b00001) begin errs++; $display("FAIL preempt_grant: got %b want 00001", GRANT); end
        @(negedge BUS_CLK); PREEMPT_REQ = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge BUS_CLK); #1;
            if (GRANT === 5'b10000) begin ok = 1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL preempt_regrant: got %b want 10000", GRANT); end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge BUS_CLK); #1;
            if (SRC_EMPTY[4] && GRANT === 5'b0 && OUT_EMPTY === 1'b1) begin ok = 1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL preempt_done: got grant=%b want drained", GRANT); end
        @(negedge BUS_CLK); OUT_READ = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++)
            if (sb + k >= src_log.size() || src_log[sb + k] != exp_src[k]) bad++;
        vecs++; if (bad != 0 || src_log.size() - sb != 12) begin
            errs++; $display("FAIL preempt_src_order: got %0d pops %0d wrong want 12 0", src_log.size() - sb, bad);
        end
        bad = 0;
        for (int k = 0; k < 12; k++)
            if (ob + k >= out_log.size() || out_log[ob + k] !== exp_w[k]) bad++;
        vecs++; if (bad != 0 || out_log.size() - ob != 12) begin
            errs++; $display("FAIL preempt_words: got %0d words %0d wrong want 12 0", out_log.size() - ob, bad);
        end
    endtask

    task automatic test_stall();
        int ob, sb, bad;
        bit ok;
        do_reset();
        ob = out_log.size();
        sb = src_log.size();
        @(negedge BUS_CLK);
        for (int k = 0; k < 5; k++) push_word(1, 32'h1100_0000 + k);
        OUT_READ = 1'b0;
        repeat (8) @(negedge BUS_CLK);
        #2;
        vecs++; if (src_log.size() - sb != 2) begin errs++; $display("FAIL stall_pops: got %0d want 2", src_log.size() - sb); end
        vecs++; if (SRC_READ !== 5'b0) begin errs++; $display("FAIL stall_src_read: got %b want 00000", SRC_READ); end
        vecs++; if (OUT_EMPTY !== 1'b0 || OUT_DATA !== 32'h1100_0000) begin
            errs++; $display("FAIL stall_head: got empty=%b data=%h want 0 11000000", OUT_EMPTY, OUT_DATA);
        end
        vecs++; if (GRANT !== 5'b00010) begin errs++; $display("FAIL stall_grant: got %b want 00010", GRANT); end
        @(negedge BUS_CLK); OUT_READ = 1'b1;
        ok = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge BUS_CLK); #1;
            if (SRC_EMPTY[1] && GRANT === 5'b0 && OUT_EMPTY === 1'b1) begin ok = 1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL stall_done: got grant=%b want drained", GRANT); end
        @(negedge BUS_CLK); OUT_READ = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (ob + k >= out_log.size() || out_log[ob + k] !== 32'h1100_0000 + k) bad++;
        vecs++; if (bad != 0 || out_log.size() - ob != 5) begin
            errs++; $display("FAIL stall_words: got %0d words %0d wrong want 5 0", out_log.size() - ob, bad);
        end
    endtask

    task automatic test_err_and_async_reset();
        int e0;
        do_reset();
        e0 = err_cnt;
        @(negedge BUS_CLK); OUT_READ = 1'b1;
        @(posedge BUS_CLK); #1;
        vecs++; if (OUT_READ_ERR !== 1'b1) begin errs++; $display("FAIL err_pulse: got %b want 1", OUT_READ_ERR); end
        @(negedge BUS_CLK); OUT_READ = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        #2;
        vecs++; if (err_cnt - e0 != 1) begin errs++; $display("FAIL err_width: got %0d cycles want 1", err_cnt - e0); end
        vecs++; if (OUT_EMPTY !== 1'b1) begin errs++; $display("FAIL err_buffer: got empty=%b want 1", OUT_EMPTY); end

        @(negedge BUS_CLK);
        for (int k = 0; k < 4; k++) push_word(2, 32'h2200_0000 + k);
        repeat (6) @(negedge BUS_CLK);
        #2;
        vecs++; if (OUT_EMPTY !== 1'b0 || GRANT !== 5'b00100) begin
            errs++; $display("FAIL arst_setup: got empty=%b grant=%b want 0 00100", OUT_EMPTY, GRANT);
        end
        BUS_RST = 1'b1;
        #1;
        vecs++; if (OUT_EMPTY !== 1'b1) begin errs++; $display("FAIL arst_empty: got %b want 1", OUT_EMPTY); end
        vecs++; if (OUT_DATA !== 32'h0) begin errs++; $display("FAIL arst_data: got %h want 0", OUT_DATA); end
        vecs++; if (GRANT !== 5'b0) begin errs++; $display("FAIL arst_grant: got %b want 00000", GRANT); end
        vecs++; if (SRC_READ !== 5'b0) begin errs++; $display("FAIL arst_src_read: got %b want 00000", SRC_READ); end
        OUT_READ = 1'b1;
        @(posedge BUS_CLK); #1;
        vecs++; if (SRC_READ !== 5'b0 || OUT_READ_ERR !== 1'b0) begin
            errs++; $display("FAIL arst_hold: got src_read=%b err=%b want 00000 0", SRC_READ, OUT_READ_ERR);
        end
        @(negedge BUS_CLK);
        OUT_READ = 1'b0;
        for (int i = 0; i < N; i++) wr[i] = rd[i];
        BUS_RST = 1'b0;
    endtask

    initial begin
        BUS_RST = 1'b1;
        OUT_READ = 1'b0;
        PREEMPT_REQ = 1'b0;
        test_reset();
        test_basic();
        test_bursts();
        test_preempt();
        test_stall();
        test_err_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
